// File: rtl/sap_cg_pkg.sv
// Shared types and constants for the SAP clock-gating controller.
package sap_cg_pkg;

  localparam int unsigned WAKE_CNT_W = 4;

  typedef enum logic [1:0] {
    StActive = 2'd0,
    StDrain  = 2'd1,
    StGated  = 2'd2,
    StWake   = 2'd3
  } cg_state_e;

endpackage

// File: rtl/sap_cg_domain_fsm.sv
// One gated domain: idle run-length counter, drain handshake, wake settle sequencing.
// Optional gated-cycle statistic under SAP_CG_STATS_EN.
module sap_cg_domain_fsm
  import sap_cg_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned WAKE_CYCLES = 2
`ifdef SAP_CG_STATS_EN
  ,
  parameter int unsigned STAT_W      = 32
`endif
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             test_en_i,
  input  logic [CNT_W-1:0] cfg_idle_thresh_i,
  input  logic             idle_i,
  input  logic             wake_req_i,
  input  logic             sleep_ack_i,
  output logic             sleep_req_o,
  output logic             clk_en_o,
  output logic             ready_o
`ifdef SAP_CG_STATS_EN
  ,
  output logic [STAT_W-1:0] gated_cnt_o
`endif
);

  localparam logic [WAKE_CNT_W-1:0] WakeLast = WAKE_CNT_W'(WAKE_CYCLES - 1);

  cg_state_e              state_q, state_d;
  logic [CNT_W-1:0]       idle_cnt_q, idle_cnt_d;
  logic [WAKE_CNT_W-1:0]  wake_cnt_q, wake_cnt_d;
  logic                   clk_en_q, ready_q, sleep_req_q;

  logic                   idle_hit;
  logic                   thresh_nz;
  logic [CNT_W:0]         cnt_inc;
  logic                   go_drain;

  assign idle_hit  = idle_i & ~wake_req_i;
  assign thresh_nz = |cfg_idle_thresh_i;
  assign cnt_inc   = {1'b0, idle_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  // Compare against the incremented count so DRAIN lands on the edge the count reaches T;
  // >= also covers a threshold lowered below the running count.
  assign go_drain  = thresh_nz & idle_hit & (cnt_inc >= {1'b0, cfg_idle_thresh_i});

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = '0;
    wake_cnt_d = '0;
    if (test_en_i) begin
      state_d = StActive;
    end else begin
      unique case (state_q)
        StActive: begin
          if (go_drain) begin
            state_d    = StDrain;
            idle_cnt_d = cfg_idle_thresh_i;
          end else if (idle_hit && thresh_nz) begin
            idle_cnt_d = cnt_inc[CNT_W-1:0];
          end
        end
        StDrain: begin
          if (wake_req_i) begin
            state_d = StActive;
          end else if (sleep_ack_i) begin
            state_d = StGated;
          end
        end
        StGated: begin
          if (wake_req_i) begin
            state_d = StWake;
          end
        end
        StWake: begin
          if (wake_cnt_q == WakeLast) begin
            state_d = StActive;
          end else begin
            wake_cnt_d = wake_cnt_q + 1'b1;
          end
        end
        default: state_d = StActive;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StActive;
      idle_cnt_q  <= '0;
      wake_cnt_q  <= '0;
      clk_en_q    <= 1'b1;
      ready_q     <= 1'b1;
      sleep_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      wake_cnt_q  <= wake_cnt_d;
      // Outputs decoded from next state so they come straight from flops.
      clk_en_q    <= (state_d != StGated);
      ready_q     <= (state_d == StActive);
      sleep_req_q <= (state_d == StDrain);
    end
  end

  assign clk_en_o    = clk_en_q;
  assign ready_o     = ready_q;
  assign sleep_req_o = sleep_req_q;

`ifdef SAP_CG_STATS_EN
  logic [STAT_W-1:0] gated_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gated_cnt_q <= '0;
    end else if (state_q == StGated) begin
      gated_cnt_q <= gated_cnt_q + 1'b1;
    end
  end

  assign gated_cnt_o = gated_cnt_q;
`endif

endmodule

// File: rtl/sap_clock_gate_ctrl.sv
// Per-domain clock-gating controller driving clock-gate cell enables.
// Define SAP_CG_STATS_EN to add per-domain gated-cycle counters on gated_cnt_o.
module sap_clock_gate_ctrl
  import sap_cg_pkg::*;
#(
  parameter int unsigned N_DOM       = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned STAT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             test_en_i,
  input  logic [CNT_W-1:0] cfg_idle_thresh_i,
  input  logic [N_DOM-1:0] idle_i,
  input  logic [N_DOM-1:0] wake_req_i,
  input  logic [N_DOM-1:0] sleep_ack_i,
  output logic [N_DOM-1:0] sleep_req_o,
  output logic [N_DOM-1:0] clk_en_o,
  output logic [N_DOM-1:0] ready_o
`ifdef SAP_CG_STATS_EN
  ,
  output logic [N_DOM*STAT_W-1:0] gated_cnt_o
`endif
);

  if (WAKE_CYCLES < 1 || WAKE_CYCLES > 15 || STAT_W < 1) begin : g_bad_param
    $error("sap_clock_gate_ctrl: WAKE_CYCLES must be 1..15 and STAT_W nonzero");
  end

  logic [N_DOM-1:0] clk_en_fsm;

  for (genvar d = 0; d < N_DOM; d++) begin : g_dom
    sap_cg_domain_fsm #(
      .CNT_W       (CNT_W),
      .WAKE_CYCLES (WAKE_CYCLES)
`ifdef SAP_CG_STATS_EN
      ,
      .STAT_W      (STAT_W)
`endif
    ) u_fsm (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .test_en_i         (test_en_i),
      .cfg_idle_thresh_i (cfg_idle_thresh_i),
      .idle_i            (idle_i[d]),
      .wake_req_i        (wake_req_i[d]),
      .sleep_ack_i       (sleep_ack_i[d]),
      .sleep_req_o       (sleep_req_o[d]),
      .clk_en_o          (clk_en_fsm[d]),
      .ready_o           (ready_o[d])
`ifdef SAP_CG_STATS_EN
      ,
      .gated_cnt_o       (gated_cnt_o[d*STAT_W +: STAT_W])
`endif
    );
  end

  // test_en_i is static, so ORing it onto a flop output keeps en_i glitch-free.
  assign clk_en_o = clk_en_fsm | {N_DOM{test_en_i}};

endmodule

// File: doc/sap_clock_gate_ctrl.md
# sap_clock_gate_ctrl

Per-domain clock-gating controller for the SAP subsystem. Drives the `en_i` inputs of N clock-gate cells. For each domain it:
- watches an idle indication and gates the domain's clock after a programmable run of idle cycles;
- performs a request/acknowledge drain handshake before gating;
- sequences wake-up with a fixed settle delay before reporting the domain ready.

It runs on the ungated clock, next to the clock-gate cells it controls.

## Interface
- `N_DOM`, default 4: number of gated domains.
- `CNT_W`, default 8: width of the idle-threshold counter.
- `WAKE_CYCLES`, default 2: cycles from enable reassertion to `ready_o`. Range 1..15.
- `STAT_W`, default 32: gated-cycle statistic width, used only under the macro.

Ports (name, direction, width, meaning):
- `clk_i` in 1: free-running clock, never gated.
- `rst_i` in 1: reset, asynchronous, active-high.
- `test_en_i` in 1: test mode. Forces all `clk_en_o` high and holds every FSM in ACTIVE.
- `cfg_idle_thresh_i` in CNT_W: idle cycles required before draining. 0 disables gating.
- `idle_i` in N_DOM: domain reports idle, one bit per domain.
- `wake_req_i` in N_DOM: level request to run the domain.
- `sleep_ack_i` in N_DOM: domain has drained and accepts gating.
- `sleep_req_o` out N_DOM: drain request to the domain.
- `clk_en_o` out N_DOM: to the gate cell `en_i`.
- `ready_o` out N_DOM: domain clock is running and settled.
- `gated_cnt_o` out N_DOM×STAT_W: cycles spent in GATED. Present only with `SAP_CG_STATS_EN`.

## Operation
- Each domain has an independent FSM with states ACTIVE, DRAIN, GATED and WAKE.
- Reset values:
  - State is ACTIVE.
  - `clk_en_o` = all 1; `ready_o` = all 1; `sleep_req_o` = 0.
  - Idle counter = 0; wake counter = 0; `gated_cnt_o` = 0.
- **ACTIVE:**
  - `clk_en_o`=1, `ready_o`=1.
  - The idle counter increments when `idle_i` is 1 and `wake_req_i` is 0. Otherwise it clears.
  - The counter saturates at `cfg_idle_thresh_i`.
  - When counter == threshold and threshold != 0 → DRAIN.
- **DRAIN:**
  - `sleep_req_o`=1, `clk_en_o`=1, `ready_o`=0.
  - `wake_req_i` → ACTIVE, with `sleep_req_o` dropped and the counter cleared. This abort has priority over `sleep_ack_i` in the same cycle.
  - Otherwise `sleep_ack_i` → GATED.
  - DRAIN has no timeout and waits indefinitely.
- **GATED:**
  - `clk_en_o`=0, `sleep_req_o`=0, `ready_o`=0.
  - `wake_req_i` → WAKE.
- **WAKE:**
  - `clk_en_o`=1, `ready_o`=0.
  - The wake counter counts up from 0. At `WAKE_CYCLES-1` → ACTIVE, with the idle counter cleared.
  - `wake_req_i` falling during WAKE does not abort the wake.
- `sleep_ack_i` outside DRAIN is ignored.
- A threshold change takes effect on the next compare. If the new threshold is below the current count, the compare is ≥ and DRAIN is entered next cycle.
- **`test_en_i`:**
  - All FSMs are forced to ACTIVE on the next edge and counters clear.
  - `clk_en_o` is ORed with `test_en_i` combinationally, so it is high in the same cycle.
- **Async reset mid-operation:** returns immediately to the reset values, including from GATED. The clock is re-enabled without a drain.

## Timing
- All outputs except the `test_en_i` OR path are registered (state-decoded flops).
- Idle-to-gating timing, with threshold T, idle_i asserted at cycle 0 and `sleep_ack_i` held 1:
  - `sleep_req_o` rises at edge T.
  - `clk_en_o` falls at edge T+1.
- Wake timing, with `wake_req_i` asserted in GATED at cycle 0:
  - `clk_en_o` rises at edge 1.
  - `ready_o` rises at edge 1+WAKE_CYCLES.
- Minimum GATED dwell is 1 cycle.
- The gate cell latches `en_i` while its clock is low. `clk_en_o` must therefore be glitch-free: it comes from a flop, ORed only with `test_en_i`, which is static.

## Configuration
- `SAP_CG_STATS_EN`:
  - **Defined:** per-domain STAT_W counter, incrementing each cycle the domain is in GATED. It wraps modulo 2^STAT_W, clears on reset and is exposed on `gated_cnt_o`.
  - **Undefined:** the port and counters are absent.

## Structure
- Package `sap_cg_pkg` holds:
  - `cg_state_e` (ACTIVE, DRAIN, GATED, WAKE; 2-bit encoding);
  - the `WAKE_CNT_W` = 4 constant.
- Sub-module `sap_cg_domain_fsm`: one domain's FSM, idle counter, wake counter and optional stats counter.
- The top module instantiates `sap_cg_domain_fsm` N_DOM times and performs the `test_en_i` OR.

## Test plan
- **Reset:** assert `rst_i` mid-GATED → same cycle `clk_en_o`=1111 and `ready_o`=1111; after release, ACTIVE.
- **Idle gating:** T=5, `idle_i[0]`=1, ack tied 1 → `sleep_req_o[0]` at edge 5, `clk_en_o[0]`=0 at edge 6; other domains stay enabled.
- **Wake:** from GATED, `wake_req_i[2]` pulsed 1 cycle, WAKE_CYCLES=2 → `clk_en_o[2]` at edge 1, `ready_o[2]` at edge 3.
- **Drain abort:** `wake_req_i` and `sleep_ack_i` both high in DRAIN → returns to ACTIVE, `clk_en_o` never drops, counter restarts from 0.
- **Disable and test mode:** T=0 with idle held 1000 cycles → never gates. `test_en_i`=1 while GATED → `clk_en_o`=1 in the same cycle, FSM ACTIVE next edge.
- **Stats (`SAP_CG_STATS_EN`):** gate for 37 cycles → `gated_cnt_o[1]`=37. Force wrap at STAT_W=4 → 16 gated cycles read 0.
